// File: rtl/rtclock_pkg.sv
// rtclock_pkg: shared types and constants for the rtclock time base.
//   state_t        - load sequencer states (IDLE / PENDING / RELEASE)
//   GNT_CPU/SYNC   - grant identifiers, also the bit index in one-hot grants
//   RTC_SEC_W      - width of the seconds counter
//   NS_W_DEF       - default width of the nanosecond counter
//   NS_PER_SEC_DEF - default nanosecond rollover modulus
package rtclock_pkg;

    localparam int RTC_SEC_W      = 64;
    localparam int NS_W_DEF       = 30;
    localparam int NS_PER_SEC_DEF = 1000000000;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_SYNC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rtclock_timebase_ctrl_if.sv
// rtclock_timebase_ctrl_if: groups the load handshakes and time-base outputs.
//   master - requester side (CPU register block / time-sync logic)
//   slave  - the time-base controller
//
// Handshake: cpu_req/sync_req are levels. A requester raises req with its
// seconds value stable and holds both until it sees the matching 1-cycle ack,
// then drops req in the following cycle. A req still high after that is a new
// request. state_dbg exposes the sequencer state for observation only.
interface rtclock_timebase_ctrl_if #(
    parameter int NS_W = rtclock_pkg::NS_W_DEF
);
    import rtclock_pkg::*;

    logic                 enable;
    logic                 cpu_req;
    logic [RTC_SEC_W-1:0] cpu_sec;
    logic                 cpu_ack;
    logic                 sync_req;
    logic [RTC_SEC_W-1:0] sync_sec;
    logic                 sync_ack;
    logic [RTC_SEC_W-1:0] sec_state;
    logic [NS_W-1:0]      ns_state;
    logic                 pps;
    logic                 busy;
    state_t               state_dbg;

    modport master (
        output enable, cpu_req, cpu_sec, sync_req, sync_sec,
        input  cpu_ack, sync_ack, sec_state, ns_state, pps, busy, state_dbg
    );

    modport slave (
        input  enable, cpu_req, cpu_sec, sync_req, sync_sec,
        output cpu_ack, sync_ack, sec_state, ns_state, pps, busy, state_dbg
    );

endinterface

// File: rtl/rtclock_timebase_ctrl_rr_arb.sv
// rtclock_rr_arb: two-requester round-robin arbiter.
//   clk, reset - clock and synchronous active-high reset
//   en         - grants are only produced while en=1
//   req[1:0]   - request levels, indexed by GNT_CPU / GNT_SYNC
//   gnt[1:0]   - one-hot grant (combinational), same indexing
// On a tie the requester that did not win last time is granted. last_grant
// resets to SYNC so the first tie goes to the CPU.
module rtclock_rr_arb
    import rtclock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == GNT_SYNC) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_SYNC;
        end else if (|gnt) begin
            last_grant <= gnt[GNT_SYNC] ? GNT_SYNC : GNT_CPU;
        end
    end

endmodule

// File: rtl/rtclock_timebase_ctrl.sv
// rtclock_timebase_ctrl: nanosecond/second time base with sequenced loads.
//   clk   - single clock
//   reset - synchronous active-high reset
//   bus   - slave modport: enable, cpu/sync load handshakes, sec_state,
//           ns_state, pps, busy, state_dbg
// The ns counter advances by NS_INC per enabled cycle and carries the
// remainder across NS_PER_SEC. A granted load is held in pend_sec and
// replaces the +1 at the next second boundary; with the time base stopped it
// commits on the next edge and clears ns instead.
module rtclock_timebase_ctrl
    import rtclock_pkg::*;
#(
    parameter int NS_INC     = 4,
    parameter int NS_PER_SEC = NS_PER_SEC_DEF,
    parameter int NS_W       = NS_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    rtclock_timebase_ctrl_if.slave bus
);

    localparam logic [NS_W:0] INC_W = (NS_W+1)'(NS_INC);
    localparam logic [NS_W:0] PER_W = (NS_W+1)'(NS_PER_SEC);

    state_t               state;
    logic [RTC_SEC_W-1:0] pend_sec;
    logic                 pend_is_sync;
    logic [RTC_SEC_W-1:0] sec_q;
    logic [NS_W-1:0]      ns_q;
    logic                 pps_q;
    logic                 cpu_ack_q;
    logic                 sync_ack_q;

    logic [NS_W:0]        ns_next;
    logic                 rollover;
    logic [NS_W-1:0]      ns_after;
    logic [1:0]           gnt;

    // One extra bit so ns + NS_INC never wraps before the compare.
    always_comb begin
        ns_next  = {1'b0, ns_q} + INC_W;
        rollover = (ns_next >= PER_W);
        ns_after = rollover ? NS_W'(ns_next - PER_W) : NS_W'(ns_next);
    end

    rtclock_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_IDLE),
        .req   ({bus.sync_req, bus.cpu_req}),
        .gnt   (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pend_sec     <= '0;
            pend_is_sync <= 1'b0;
            sec_q        <= '0;
            ns_q         <= '0;
            pps_q        <= 1'b0;
            cpu_ack_q    <= 1'b0;
            sync_ack_q   <= 1'b0;
        end else begin
            pps_q      <= 1'b0;
            cpu_ack_q  <= 1'b0;
            sync_ack_q <= 1'b0;

            if (bus.enable) begin
                ns_q <= ns_after;
                if (rollover) begin
                    sec_q <= sec_q + 1'b1;
                    pps_q <= 1'b1;
                end
            end

            // Later assignments below override the free-running update above.
            case (state)
                ST_IDLE: begin
                    if (gnt[GNT_CPU]) begin
                        pend_sec     <= bus.cpu_sec;
                        pend_is_sync <= 1'b0;
                        state        <= ST_PENDING;
                    end else if (gnt[GNT_SYNC]) begin
                        pend_sec     <= bus.sync_sec;
                        pend_is_sync <= 1'b1;
                        state        <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (!bus.enable || rollover) begin
                        sec_q <= pend_sec;
                        // Stopped time base: nothing to align to, so start
                        // the new second from zero.
                        if (!bus.enable) begin
                            ns_q <= '0;
                        end
                        if (pend_is_sync) begin
                            sync_ack_q <= 1'b1;
                        end else begin
                            cpu_ack_q <= 1'b1;
                        end
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Gives the acked requester a cycle to drop req.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sec_state = sec_q;
    assign bus.ns_state  = ns_q;
    assign bus.pps       = pps_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.sync_ack  = sync_ack_q;
    assign bus.busy      = (state == ST_PENDING);
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_rtclock_timebase_ctrl.sv
module tb_rtclock_timebase_ctrl;

  localparam int NS_PER = 100;
  localparam int NS_W   = 30;

  logic clk;
  logic reset;

  rtclock_timebase_ctrl_if #(.NS_W(NS_W)) bus0 ();
  rtclock_timebase_ctrl_if #(.NS_W(NS_W)) bus1 ();

  rtclock_timebase_ctrl #(.NS_INC(4), .NS_PER_SEC(NS_PER), .NS_W(NS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  rtclock_timebase_ctrl #(.NS_INC(7), .NS_PER_SEC(NS_PER), .NS_W(NS_W)) dut7 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // ---------------- behavioural model ----------------
  // Time is tracked as (seconds, ns) with plain arithmetic; a load is a
  // pending value that lands on the next boundary (or immediately when
  // stopped), followed by one dead cycle before the next grant.
  int          m_inc [2] = '{4, 7};
  logic [63:0] m_sec [2];
  int          m_ns [2];
  bit          m_pps [2];
  bit          m_cack [2];
  bit          m_sack [2];
  bit          m_has_load [2];
  bit          m_dead [2];
  bit          m_prefer_cpu [2];
  bit          m_load_sync [2];
  logic [63:0] m_load [2];

  task automatic model_step(input int i, input bit rst, input bit en,
                            input bit creq, input bit sreq,
                            input logic [63:0] csec, input logic [63:0] ssec);
    int t;
    bit boundary;
    if (rst) begin
      m_sec[i] = '0; m_ns[i] = 0; m_pps[i] = 0; m_cack[i] = 0; m_sack[i] = 0;
      m_has_load[i] = 0; m_dead[i] = 0; m_prefer_cpu[i] = 1; m_load_sync[i] = 0;
      m_load[i] = '0;
      return;
    end
    m_pps[i] = 0; m_cack[i] = 0; m_sack[i] = 0;
    boundary = 0;
    if (en) begin
      t = m_ns[i] + m_inc[i];
      boundary = (t >= NS_PER);
      m_ns[i] = t % NS_PER;
      if (boundary) begin
        m_sec[i] = m_sec[i] + 64'd1;
        m_pps[i] = 1;
      end
    end
    if (m_has_load[i]) begin
      if (!en || boundary) begin
        m_sec[i] = m_load[i];
        if (!en) m_ns[i] = 0;
        if (m_load_sync[i]) m_sack[i] = 1; else m_cack[i] = 1;
        m_has_load[i] = 0;
        m_dead[i] = 1;
      end
    end else if (m_dead[i]) begin
      m_dead[i] = 0;
    end else if (creq && (!sreq || m_prefer_cpu[i])) begin
      m_has_load[i] = 1; m_load_sync[i] = 0; m_load[i] = csec; m_prefer_cpu[i] = 0;
    end else if (sreq) begin
      m_has_load[i] = 1; m_load_sync[i] = 1; m_load[i] = ssec; m_prefer_cpu[i] = 1;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    model_step(0, reset, bus0.enable, bus0.cpu_req, bus0.sync_req, bus0.cpu_sec, bus0.sync_sec);
    model_step(1, reset, bus1.enable, bus1.cpu_req, bus1.sync_req, bus1.cpu_sec, bus1.sync_sec);
    #1;
    cmp("d4.sec", bus0.sec_state, m_sec[0]);
    cmp("d4.ns", 64'(bus0.ns_state), 64'(m_ns[0]));
    cmp("d4.pps", 64'(bus0.pps), 64'(m_pps[0]));
    cmp("d4.cpu_ack", 64'(bus0.cpu_ack), 64'(m_cack[0]));
    cmp("d4.sync_ack", 64'(bus0.sync_ack), 64'(m_sack[0]));
    cmp("d4.busy", 64'(bus0.busy), 64'(m_has_load[0]));
    cmp("d7.sec", bus1.sec_state, m_sec[1]);
    cmp("d7.ns", 64'(bus1.ns_state), 64'(m_ns[1]));
    cmp("d7.pps", 64'(bus1.pps), 64'(m_pps[1]));
    cmp("d7.busy", 64'(bus1.busy), 64'(m_has_load[1]));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel: 0 cpu_ack, 1 sync_ack, 2 pps, 3 ns_state==40 (all on dut)
  task automatic wait_for(input int sel, input int budget, input string nm);
    bit hit;
    hit = 0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      case (sel)
        0: hit = bus0.cpu_ack;
        1: hit = bus0.sync_ack;
        2: hit = bus0.pps;
        default: hit = (bus0.ns_state == 40);
      endcase
    end
    n_vec++;
    if (!hit) begin
      n_mis++;
      $display("FAIL wait_%s: event not seen within %0d cycles, required 1", nm, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  bit ack_seen;

  initial begin
    reset = 1'b1;
    bus0.enable = 0; bus0.cpu_req = 0; bus0.sync_req = 0; bus0.cpu_sec = '0; bus0.sync_sec = '0;
    bus1.enable = 0; bus1.cpu_req = 0; bus1.sync_req = 0; bus1.cpu_sec = '0; bus1.sync_sec = '0;
    tick(3);
    cmp("rst.sec", bus0.sec_state, 64'd0);
    cmp("rst.ns", 64'(bus0.ns_state), 64'd0);
    cmp("rst.busy", 64'(bus0.busy), 64'd0);
    cmp("rst.pps", 64'(bus0.pps), 64'd0);

    // Free-running counters: INC=4 -> pps every 25 edges; INC=7 -> 15 then 14.
    reset = 1'b0;
    bus0.enable = 1; bus1.enable = 1;
    tick(1);
    cmp("run.ns_first", 64'(bus0.ns_state), 64'd4);
    tick(14);
    cmp("run7.ns_after_15", 64'(bus1.ns_state), 64'd5);
    cmp("run7.pps_15", 64'(bus1.pps), 64'd1);
    cmp("run7.sec_15", bus1.sec_state, 64'd1);
    tick(10);
    cmp("run.sec_25", bus0.sec_state, 64'd1);
    cmp("run.ns_25", 64'(bus0.ns_state), 64'd0);
    cmp("run.pps_25", 64'(bus0.pps), 64'd1);
    tick(4);
    cmp("run7.ns_after_29", 64'(bus1.ns_state), 64'd3);
    cmp("run7.sec_29", bus1.sec_state, 64'd2);
    tick(25);
    cmp("run.sec_54", bus0.sec_state, 64'd2);
    cmp("run.ns_54", 64'(bus0.ns_state), 64'd16);

    // Tie: CPU wins first (last grant was SYNC), sync follows a second later.
    bus0.cpu_req = 1; bus0.cpu_sec = 64'h10;
    bus0.sync_req = 1; bus0.sync_sec = 64'h20;
    wait_for(0, 40, "tie_cpu_ack");
    cmp("tie.sec_cpu", bus0.sec_state, 64'h10);
    cmp("tie.pps_cpu", 64'(bus0.pps), 64'd1);
    cmp("tie.sync_ack_early", 64'(bus0.sync_ack), 64'd0);
    bus0.cpu_req = 0;
    wait_for(1, 60, "tie_sync_ack");
    cmp("tie.sec_sync", bus0.sec_state, 64'h20);
    cmp("tie.pps_sync", 64'(bus0.pps), 64'd1);
    bus0.sync_req = 0;
    tick(2);

    // Single CPU load issued at ns=40.
    wait_for(3, 30, "ns40");
    bus0.cpu_req = 1; bus0.cpu_sec = 64'h0000_0000_6543_2100;
    tick(1);
    cmp("cpu.busy", 64'(bus0.busy), 64'd1);
    wait_for(0, 40, "cpu_ack");
    cmp("cpu.sec", bus0.sec_state, 64'h0000_0000_6543_2100);
    cmp("cpu.pps", 64'(bus0.pps), 64'd1);
    cmp("cpu.busy_after", 64'(bus0.busy), 64'd0);
    bus0.cpu_req = 0;
    tick(2);

    // Stopped time base: sync load commits right away with ns cleared.
    bus0.enable = 0;
    bus0.sync_req = 1; bus0.sync_sec = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(1);
    cmp("stop.busy", 64'(bus0.busy), 64'd1);
    tick(1);
    cmp("stop.sync_ack", 64'(bus0.sync_ack), 64'd1);
    cmp("stop.sec", bus0.sec_state, 64'hFFFF_FFFF_FFFF_FFFF);
    cmp("stop.ns", 64'(bus0.ns_state), 64'd0);
    cmp("stop.pps", 64'(bus0.pps), 64'd0);
    bus0.sync_req = 0;
    tick(2);
    bus0.enable = 1;
    wait_for(2, 30, "wrap_pps");
    cmp("wrap.sec", bus0.sec_state, 64'd0);
    cmp("wrap.ns", 64'(bus0.ns_state), 64'd0);

    // Reset while a load is pending.
    bus0.cpu_req = 1; bus0.cpu_sec = 64'h99;
    tick(2);
    cmp("rstp.busy_before", 64'(bus0.busy), 64'd1);
    reset = 1; bus0.cpu_req = 0;
    tick(1);
    cmp("rstp.sec", bus0.sec_state, 64'd0);
    cmp("rstp.ns", 64'(bus0.ns_state), 64'd0);
    cmp("rstp.busy", 64'(bus0.busy), 64'd0);
    reset = 0;
    ack_seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      ack_seen |= bus0.cpu_ack | bus0.sync_ack;
    end
    cmp("rstp.no_ack", 64'(ack_seen), 64'd0);
    bus0.cpu_req = 1; bus0.cpu_sec = 64'h77;
    wait_for(0, 40, "reissue_ack");
    cmp("reissue.sec", bus0.sec_state, 64'h77);
    bus0.cpu_req = 0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
